// File: rtl/bram_to_axis_pkg.sv
// bram_to_axis_pkg: state encodings and default sizes shared by the data mover stages
package bram_to_axis_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_t;
  localparam int DEF_CNT_BIT = 31;
  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 12;
  localparam int DEF_MEM_SIZE = 4096;
endpackage

// File: rtl/bram_to_axis_if.sv
// bram_to_axis_if: AXI4-Stream beat bundle with master/slave views
interface bram_to_axis_if import bram_to_axis_pkg::*; #(parameter int DW = DEF_DWIDTH);
  logic [DW-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/bram_to_axis_fifo2.sv
// axis_fifo2: 2-entry FIFO whose head register drives the stream directly
module axis_fifo2 #(parameter int W = 33) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic valid_o,
  output logic [1:0] cnt_o
);
  logic [W-1:0] h_q, s_q;
  logic [1:0] cnt_q;
  assign dout_o = h_q;
  assign valid_o = cnt_q != 2'd0;
  assign cnt_o = cnt_q;
  // head holds until popped; second slot refills the head or catches a push behind it
  always_ff @(posedge clk)
    if (rst) begin
      h_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop_i))) h_q <= din_i;
      else if (pop_i && cnt_q == 2'd2) h_q <= s_q;
      if (push_i && (cnt_q == 2'd1 ? !pop_i : cnt_q == 2'd2)) s_q <= din_i;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
endmodule

// File: rtl/bram_to_axis.sv
// bram_to_axis: streams num_cnt bram1 words out as AXIS; BRAM_TO_AXIS_STALL_CNT_EN adds o_stall_cnt
module bram_to_axis import bram_to_axis_pkg::*; #(
  parameter int CNT_BIT = DEF_CNT_BIT,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  output logic o_idle,
  output logic o_read,
  output logic o_done,
  output logic [AWIDTH-1:0] addr_b1,
  output logic ce_b1,
  output logic we_b1,
  output logic [DWIDTH-1:0] d_b1,
  input  logic [DWIDTH-1:0] q_b1,
`ifdef BRAM_TO_AXIS_STALL_CNT_EN
  output logic [31:0] o_stall_cnt,
`endif
  bram_to_axis_if.master m_axis
);
  localparam logic [CNT_BIT-1:0] ONE = CNT_BIT'(1);
  if (MEM_SIZE > (1 << AWIDTH)) begin : g_chk
    $error("MEM_SIZE exceeds the BRAM address space");
  end
  state_t state_q;
  logic [CNT_BIT-1:0] num_q, rd_cnt_q, tx_cnt_q;
  logic inflight_q, inflight_last_q, pop, fifo_valid;
  logic [1:0] fifo_cnt;
  logic [DWIDTH:0] fifo_dout;
  assign pop = m_axis.tvalid && m_axis.tready;
  assign ce_b1 = o_read && (rd_cnt_q < num_q) && ({1'b0, fifo_cnt} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
  assign addr_b1 = rd_cnt_q[AWIDTH-1:0];
  assign we_b1 = 1'b0;
  assign d_b1 = '0;
  assign m_axis.tvalid = fifo_valid;
  assign m_axis.tdata = fifo_dout[DWIDTH-1:0];
  assign m_axis.tlast = fifo_valid && fifo_dout[DWIDTH];
  axis_fifo2 #(.W(DWIDTH + 1)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push_i(inflight_q),
    .pop_i(pop),
    .din_i({inflight_last_q, q_b1}),
    .dout_o(fifo_dout),
    .valid_o(fifo_valid),
    .cnt_o(fifo_cnt)
  );
  // control FSM with registered status outputs, read/beat counters and read-latency tracking
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_IDLE;
      o_idle <= 1'b1;
      o_read <= 1'b0;
      o_done <= 1'b0;
      num_q <= '0;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q <= ce_b1;
      inflight_last_q <= ce_b1 && rd_cnt_q == num_q - ONE;
      if (ce_b1) rd_cnt_q <= rd_cnt_q + ONE;
      if (pop) tx_cnt_q <= tx_cnt_q + ONE;
      o_done <= 1'b0;
      unique case (state_q)
        S_IDLE: if (i_run) begin
          state_q <= S_RUN;
          o_idle <= 1'b0;
          o_read <= 1'b1;
          num_q <= i_num_cnt;
          rd_cnt_q <= '0;
          tx_cnt_q <= '0;
        end
        S_RUN: if (num_q == '0 || (pop && tx_cnt_q == num_q - ONE)) begin
          state_q <= S_DONE;
          o_read <= 1'b0;
          o_done <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          o_idle <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          o_idle <= 1'b1;
          o_read <= 1'b0;
        end
      endcase
    end
`ifdef BRAM_TO_AXIS_STALL_CNT_EN
  logic [31:0] stall_q;
  assign o_stall_cnt = stall_q;
  // saturating count of cycles the sink holds off a valid beat
  always_ff @(posedge clk)
    if (reset) stall_q <= '0;
    else if (state_q == S_IDLE && i_run) stall_q <= '0;
    else if (m_axis.tvalid && !m_axis.tready && !(&stall_q)) stall_q <= stall_q + 32'd1;
`endif
endmodule

// File: tb/tb_bram_to_axis.sv
// tb_bram_to_axis: directed scenarios for bram_to_axis; build with BRAM_TO_AXIS_STALL_CNT_EN to cover o_stall_cnt
module tb_bram_to_axis;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_run = 1'b0;
  logic [30:0] i_num_cnt = '0;
  logic o_idle, o_read, o_done, ce_b1, we_b1;
  logic [11:0] addr_b1;
  logic [31:0] d_b1;
  logic [31:0] q_b1 = '0;
  logic [31:0] stall_cnt;
  logic [31:0] mem [0:4095];
  bram_to_axis_if #(.DW(32)) axis();
  bram_to_axis dut (
    .clk(clk),
    .reset(reset),
    .i_run(i_run),
    .i_num_cnt(i_num_cnt),
    .o_idle(o_idle),
    .o_read(o_read),
    .o_done(o_done),
    .addr_b1(addr_b1),
    .ce_b1(ce_b1),
    .we_b1(we_b1),
    .d_b1(d_b1),
    .q_b1(q_b1),
`ifdef BRAM_TO_AXIS_STALL_CNT_EN
    .o_stall_cnt(stall_cnt),
`endif
    .m_axis(axis)
  );
`ifndef BRAM_TO_AXIS_STALL_CNT_EN
  assign stall_cnt = '0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) if (ce_b1) q_b1 <= mem[addr_b1];
  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int ready_mode = 0;
  always @(negedge clk)
    if (ready_mode == 1) axis.tready = 1'($urandom_range(0, 1));
    else if (ready_mode == 0) axis.tready = 1'b1;
  logic [32:0] beats[$];
  logic [32:0] held;
  int first_valid = -1, done_cyc = -1, ce_seen = 0;
  logic stall_seen = 1'b0, done_prev = 1'b0;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      stall_seen = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stall_seen) begin
        tests++;
        if (axis.tvalid !== 1'b1 || {axis.tlast, axis.tdata} !== held) begin
          fails++;
          $display("FAIL stable: got v=%b %h, want v=1 %h", axis.tvalid, {axis.tlast, axis.tdata}, held);
        end
      end
      if (ce_b1 || dut.inflight_q) begin
        tests++;
        if ((ce_b1 && int'(dut.fifo_cnt) + int'(dut.inflight_q) == 2 && !(axis.tvalid && axis.tready)) ||
            (dut.inflight_q && dut.fifo_cnt == 2'd2 && !(axis.tvalid && axis.tready))) begin
          fails++;
          $display("FAIL overflow: got fifo=%0d inflight=%b ce=%b, want room", dut.fifo_cnt, dut.inflight_q, ce_b1);
        end
      end
      if (o_done) begin
        tests++;
        if (done_prev) begin
          fails++;
          $display("FAIL done_pulse: got o_done high 2 cycles, want 1");
        end
        if (done_cyc < 0) done_cyc = cyc;
      end
      done_prev = o_done;
      if (axis.tvalid && first_valid < 0) first_valid = cyc;
      if (axis.tvalid && axis.tready) beats.push_back({axis.tlast, axis.tdata});
      if (ce_b1) ce_seen++;
      stall_seen = axis.tvalid && !axis.tready;
      held = {axis.tlast, axis.tdata};
    end
  end
  task automatic start(input int n, output int c0);
    @(negedge clk);
    i_run = 1'b1;
    i_num_cnt = 31'(n);
    c0 = cyc;
    beats.delete();
    first_valid = -1;
    done_cyc = -1;
    ce_seen = 0;
    @(negedge clk);
    i_run = 1'b0;
  endtask
  task automatic wait_done(input int budget, output bit ok);
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      @(negedge clk);
      #3;
    end
    ok = done_cyc >= 0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({o_idle, o_read, o_done, ce_b1, we_b1} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctl: got idle/read/done/ce/we=%b, want 10000", {o_idle, o_read, o_done, ce_b1, we_b1});
    end
    tests++;
    if ({axis.tvalid, axis.tlast, axis.tdata, addr_b1, d_b1} !== '0) begin
      fails++;
      $display("FAIL reset_data: got v=%b l=%b d=%h a=%h, want all 0", axis.tvalid, axis.tlast, axis.tdata, addr_b1);
    end
    reset = 1'b0;
  endtask
  task automatic test_basic;
    int c0;
    bit ok;
    ready_mode = 0;
    start(8, c0);
    wait_done(60, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout: got no o_done, want o_done"); end
    tests++;
    if (first_valid - c0 != 3) begin fails++; $display("FAIL basic_latency: got %0d, want 3", first_valid - c0); end
    tests++;
    if (done_cyc - c0 != 11) begin fails++; $display("FAIL basic_done_cyc: got %0d, want 11", done_cyc - c0); end
    tests++;
    if (beats.size() != 8) begin fails++; $display("FAIL basic_count: got %0d, want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (beats[i] !== {i == 7, 32'h100 + 32'(i)}) begin
        fails++;
        $display("FAIL basic_beat%0d: got %h, want %h", i, beats[i], {i == 7, 32'h100 + 32'(i)});
      end
    end
    @(negedge clk);
    #3;
    tests++;
    if (o_idle !== 1'b1) begin fails++; $display("FAIL basic_idle: got %b, want 1", o_idle); end
  endtask
  task automatic test_random;
    int c0;
    bit ok;
    ready_mode = 1;
    start(16, c0);
    wait_done(300, ok);
    ready_mode = 0;
    tests++;
    if (!ok) begin fails++; $display("FAIL rand_timeout: got no o_done, want o_done"); end
    tests++;
    if (beats.size() != 16) begin fails++; $display("FAIL rand_count: got %0d, want 16", beats.size()); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (beats[i] !== {i == 15, 32'h100 + 32'(i)}) begin
        fails++;
        $display("FAIL rand_beat%0d: got %h, want %h", i, beats[i], {i == 15, 32'h100 + 32'(i)});
      end
    end
  endtask
  task automatic test_zero;
    int c0;
    bit ok;
    start(0, c0);
    wait_done(10, ok);
    tests++;
    if (!ok || done_cyc - c0 != 2) begin fails++; $display("FAIL zero_done_cyc: got %0d, want 2", done_cyc - c0); end
    tests++;
    if (ce_seen != 0 || first_valid != -1) begin
      fails++;
      $display("FAIL zero_activity: got ce=%0d valid_at=%0d, want ce=0 no valid", ce_seen, first_valid);
    end
  endtask
  task automatic test_single;
    int c0;
    bit ok;
    ready_mode = 2;
    axis.tready = 1'b0;
    start(1, c0);
    repeat (7) @(negedge clk);
    axis.tready = 1'b1;
    wait_done(20, ok);
    ready_mode = 0;
    tests++;
    if (!ok || done_cyc - c0 != 9) begin fails++; $display("FAIL single_done_cyc: got %0d, want 9", done_cyc - c0); end
    tests++;
    if (beats.size() != 1 || beats[0] !== {1'b1, 32'h100}) begin
      fails++;
      $display("FAIL single_beat: got n=%0d %h, want n=1 %h", beats.size(), beats[0], {1'b1, 32'h100});
    end
`ifdef BRAM_TO_AXIS_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 32'd5) begin fails++; $display("FAIL single_stall: got %0d, want 5", stall_cnt); end
`endif
  endtask
  task automatic test_reset_mid;
    int c0;
    bit ok;
    ready_mode = 0;
    start(10, c0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #3;
    tests++;
    if (beats.size() != 3 || beats[2] !== {1'b0, 32'h102}) begin
      fails++;
      $display("FAIL mid_pre: got n=%0d last=%h, want n=3 %h", beats.size(), beats[2], {1'b0, 32'h102});
    end
    @(negedge clk);
    #1;
    tests++;
    if (axis.tvalid !== 1'b0 || o_idle !== 1'b1 || ce_b1 !== 1'b0) begin
      fails++;
      $display("FAIL mid_flush: got v=%b idle=%b ce=%b, want 0 1 0", axis.tvalid, o_idle, ce_b1);
    end
    reset = 1'b0;
    start(4, c0);
    wait_done(40, ok);
    tests++;
    if (!ok || beats.size() != 4) begin fails++; $display("FAIL mid_count: got %0d, want 4", beats.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (beats[i] !== {i == 3, 32'h100 + 32'(i)}) begin
        fails++;
        $display("FAIL mid_beat%0d: got %h, want %h", i, beats[i], {i == 3, 32'h100 + 32'(i)});
      end
    end
  endtask
`ifdef BRAM_TO_AXIS_STALL_CNT_EN
  task automatic test_stall_cnt;
    int c0;
    bit ok;
    ready_mode = 2;
    axis.tready = 1'b0;
    start(4, c0);
    repeat (9) @(negedge clk);
    axis.tready = 1'b1;
    wait_done(30, ok);
    ready_mode = 0;
    tests++;
    if (!ok || stall_cnt !== 32'd7) begin fails++; $display("FAIL stall_cnt: got %0d, want 7", stall_cnt); end
    @(negedge clk);
    #3;
    tests++;
    if (stall_cnt !== 32'd7) begin fails++; $display("FAIL stall_hold: got %0d, want 7", stall_cnt); end
  endtask
`endif
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h100 + 32'(i);
    axis.tready = 1'b1;
    test_reset();
    test_basic();
    test_random();
    test_zero();
    test_single();
    test_reset_mid();
`ifdef BRAM_TO_AXIS_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no summary by 100000, want finish");
    $fatal(1);
  end
endmodule

// File: doc/bram_to_axis.md
Name: bram_to_axis

Overview:
Downstream stage of the BRAM-to-BRAM data mover. It reads i_num_cnt words sequentially from bram1 (the mover's destination BRAM) and streams them out as an AXI4-Stream master, with tlast on the final beat. BRAM read latency is hidden behind a 2-entry output FIFO, so throughput is 1 beat/cycle under full tready and data is never lost under backpressure.

Parameters:
CNT_BIT, 31, width of the transfer-count input and internal counters
DWIDTH, 32, BRAM word and tdata width
AWIDTH, 12, BRAM address width
MEM_SIZE, 4096, BRAM depth in words (documentation bound for i_num_cnt)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
i_run  in  1  start pulse, sampled only in S_IDLE
i_num_cnt  in  CNT_BIT  number of words to stream, captured when i_run is accepted
o_idle  out  1  FSM in S_IDLE
o_read  out  1  FSM in S_RUN
o_done  out  1  FSM in S_DONE (1-cycle pulse)
addr_b1  out  AWIDTH  bram1 read address
ce_b1  out  1  bram1 chip enable (read issue)
we_b1  out  1  tied 0
d_b1  out  DWIDTH  tied 0
q_b1  in  DWIDTH  bram1 read data, valid 1 cycle after ce_b1
m_axis_tdata  out  DWIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  high on beat i_num_cnt-1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All flops clear on the posedge with reset=1, and reset overrides every other condition.
- Reset values: state S_IDLE, o_idle=1, o_read=0, o_done=0, ce_b1=0, addr_b1=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, FIFO empty, all counters 0.
- FSM: S_IDLE -(i_run)-> S_RUN; S_RUN -(handshake on last beat)-> S_DONE; S_DONE -> S_IDLE unconditionally.
- i_run is ignored outside S_IDLE.
- i_num_cnt==0: the FSM goes S_IDLE -> S_RUN -> S_DONE on consecutive edges, with no ce_b1 and no beats.
- Counters:
  - rd_cnt = reads issued.
  - tx_cnt = beats accepted.
  - Both clear when i_run is accepted.
  - addr_b1 = rd_cnt[AWIDTH-1:0]. Values of i_num_cnt above MEM_SIZE are a caller error; the address wraps modulo 2^AWIDTH.
- Read issue: ce_b1 = o_read && (rd_cnt < num_cnt) && (fifo_cnt + inflight - pop < 2).
  - pop = m_axis_tvalid && m_axis_tready.
  - inflight = ce_b1 registered one cycle.
- q_b1 is written into the FIFO on the edge ending the cycle in which inflight=1.
- FIFO is 2 entries. Its head drives tdata/tvalid. Simultaneous push and pop is allowed at any occupancy. Overflow is impossible by construction; the bench asserts it never occurs.
- Latency: i_run high in cycle 0 gives ce_b1 with addr 0 in cycle 1, q_b1 in cycle 2, and m_axis_tvalid in cycle 3. Thereafter 1 beat/cycle while tready=1.
- AXIS rules:
  - Once tvalid rises, tvalid, tdata and tlast hold stable until the handshake.
  - tvalid never depends combinationally on tready.
  - tlast = tvalid && (tx_cnt == num_cnt-1), stored alongside the data in the FIFO.
- Last handshake: S_DONE is entered on the following edge, and o_done is high for exactly 1 cycle.
- Reset mid-transfer: the FIFO is flushed, tvalid=0 on the next cycle, and the in-flight read is discarded.

Optional Feature:
- Macro BRAM_TO_AXIS_STALL_CNT_EN.
- Defined: adds output o_stall_cnt (32 bits). It counts cycles with m_axis_tvalid && !m_axis_tready, saturates at 0xFFFFFFFF, clears on reset and on accepted i_run, and holds its value after S_DONE.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10, common with the mover;
  - default DWIDTH/AWIDTH/CNT_BIT/MEM_SIZE constants.
- One sub-module: axis_fifo2, a 2-entry FIFO with push/pop/data/last/count, reusable by an upstream axis_to_bram stage.

Test Plan:
- Preload bram1[i]=i+0x100; i_num_cnt=8, tready=1 -> tvalid from cycle 3, 8 consecutive beats 0x100..0x107, tlast only on 0x107, o_done 1 cycle after the last beat, then o_idle=1.
- i_num_cnt=16, tready pseudo-random 50% -> all 16 words in order, no duplicates or drops, tdata stable while tvalid && !tready, ce_b1 never issued with fifo_cnt+inflight=2 and no pop.
- i_num_cnt=0 -> no ce_b1, no tvalid, o_done pulses 2 cycles after i_run.
- i_num_cnt=1 -> a single beat with tlast=1; tready held low 5 cycles then high -> beat accepted exactly once.
- reset=1 asserted after the 3rd beat of a 10-beat run -> next cycle tvalid=0 and o_idle=1; a new i_run with count 4 streams bram1[0..3] correctly.
- With BRAM_TO_AXIS_STALL_CNT_EN: count 4, tready low for 7 cycles while tvalid is high -> o_stall_cnt=7 after o_done.
